// File: rtl/reg_file_pkg.sv
// Shared register-file constants and types; the control unit imports the same
// package for its select ports.
package regfile_pkg;
   localparam int DATA_W   = 16;
   localparam int SEL_W    = 3;
   localparam int NUM_REGS = 8;

   typedef logic [SEL_W-1:0]  reg_idx_t;
   typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/reg_file_if.sv
// Register-select bus between the control unit (master) and the register file (slave).
// Selects and write controls are sampled on every rising clk edge; there is no
// handshake, so a write or read happens on every edge its controls are presented.
interface reg_file_if
   import regfile_pkg::*;
#(
   parameter int DATA_W = regfile_pkg::DATA_W,
   parameter int SEL_W  = regfile_pkg::SEL_W
) ();
   logic [SEL_W-1:0]  reg_sel_r0;
   logic [SEL_W-1:0]  reg_sel_r1;
   logic [SEL_W-1:0]  reg_sel_w0;
   logic              reg_w0_rw;
   logic [DATA_W-1:0] w0_data;
   logic [DATA_W-1:0] r0_data;
   logic [DATA_W-1:0] r1_data;
   logic [SEL_W-1:0]  dbg_sel;
   logic [DATA_W-1:0] dbg_data;

   modport master (
      output reg_sel_r0, reg_sel_r1, reg_sel_w0, reg_w0_rw, w0_data, dbg_sel,
      input  r0_data, r1_data, dbg_data
   );

   modport slave (
      input  reg_sel_r0, reg_sel_r1, reg_sel_w0, reg_w0_rw, w0_data, dbg_sel,
      output r0_data, r1_data, dbg_data
   );
endinterface

// File: rtl/reg_file_read_port.sv
// One registered read port: storage mux, write-to-read bypass, register-0 masking
// and the output register.
module reg_file_read_port
   import regfile_pkg::*;
#(
   parameter int DATA_W   = regfile_pkg::DATA_W,
   parameter int NUM_REGS = regfile_pkg::NUM_REGS,
   parameter int SEL_W    = regfile_pkg::SEL_W,
   parameter bit ZERO_REG = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] mem [NUM_REGS],
   input  logic [SEL_W-1:0]  rd_sel,
   input  logic              wr_en,
   input  logic [SEL_W-1:0]  wr_sel,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data
);
   logic [DATA_W-1:0] rd_next;

   // Masking wins over bypass so a discarded write to register 0 never leaks out.
   always_comb begin
      rd_next = '0;
      if (ZERO_REG && rd_sel == '0) begin
         rd_next = '0;
      end else if (wr_en && wr_sel == rd_sel) begin
         rd_next = wr_data;
      end else begin
         rd_next = mem[rd_sel];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data <= '0;
      end else begin
         rd_data <= rd_next;
      end
   end
endmodule

// File: rtl/reg_file.sv
// Register file: two registered read ports with write bypass, one synchronous
// write port and a combinational debug peek into storage.
module reg_file
   import regfile_pkg::*;
#(
   parameter int DATA_W   = regfile_pkg::DATA_W,
   parameter int NUM_REGS = regfile_pkg::NUM_REGS,
   parameter int SEL_W    = regfile_pkg::SEL_W,
   parameter bit ZERO_REG = 1'b0
) (
   input logic       clk,
   input logic       rst,
   reg_file_if.slave bus
);
   if (NUM_REGS != 2 ** SEL_W) begin : g_bad_size
      $error("reg_file: NUM_REGS must equal 2**SEL_W");
   end

   logic [DATA_W-1:0] mem [NUM_REGS];
   logic              wr_ok;
   logic [DATA_W-1:0] dbg_word;

   assign wr_ok = bus.reg_w0_rw && !(ZERO_REG && bus.reg_sel_w0 == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_ok) begin
         mem[bus.reg_sel_w0] <= bus.w0_data;
      end
   end

   reg_file_read_port #(
      .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .SEL_W(SEL_W), .ZERO_REG(ZERO_REG)
   ) u_r0 (
      .clk     (clk),
      .rst     (rst),
      .mem     (mem),
      .rd_sel  (bus.reg_sel_r0),
      .wr_en   (bus.reg_w0_rw),
      .wr_sel  (bus.reg_sel_w0),
      .wr_data (bus.w0_data),
      .rd_data (bus.r0_data)
   );

   reg_file_read_port #(
      .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .SEL_W(SEL_W), .ZERO_REG(ZERO_REG)
   ) u_r1 (
      .clk     (clk),
      .rst     (rst),
      .mem     (mem),
      .rd_sel  (bus.reg_sel_r1),
      .wr_en   (bus.reg_w0_rw),
      .wr_sel  (bus.reg_sel_w0),
      .wr_data (bus.w0_data),
      .rd_data (bus.r1_data)
   );

   // Debug peek shows storage only, never the in-flight write.
   always_comb begin
      dbg_word = mem[bus.dbg_sel];
      if (ZERO_REG && bus.dbg_sel == '0) begin
         dbg_word = '0;
      end
   end

   assign bus.dbg_data = dbg_word;
endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: two builds (ZERO_REG=0 and 1) driven in lockstep and
// checked against an array-based reference of the register file.
module tb_reg_file;
   import regfile_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   reg_file_if bus_a ();
   reg_file_if bus_b ();

   reg_file #(.ZERO_REG(1'b0)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
   reg_file #(.ZERO_REG(1'b1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

   int n_checks = 0;
   int n_errors = 0;

   // Reference storage: index 0 models the plain build, index 1 the zero-register build.
   word_t ref_mem [2][NUM_REGS];
   logic [DATA_W-1:0] exp_q[$];

   task automatic check(input string tag, input word_t got, input word_t exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic word_t ref_read(input int z, input logic rst_v, input logic we,
                                      input reg_idx_t ws, input word_t wd, input reg_idx_t rs);
      if (rst_v) return '0;
      if (z == 1 && rs == 0) return '0;
      if (we && ws == rs) return wd;
      return ref_mem[z][rs];
   endfunction

   // One clock edge: present controls, let the edge happen, then compare both builds.
   task automatic cycle(input logic rst_v, input logic we, input reg_idx_t ws, input word_t wd,
                        input reg_idx_t s0, input reg_idx_t s1, input reg_idx_t ds);
      rst = rst_v;
      bus_a.reg_w0_rw = we;  bus_b.reg_w0_rw = we;
      bus_a.reg_sel_w0 = ws; bus_b.reg_sel_w0 = ws;
      bus_a.w0_data = wd;    bus_b.w0_data = wd;
      bus_a.reg_sel_r0 = s0; bus_b.reg_sel_r0 = s0;
      bus_a.reg_sel_r1 = s1; bus_b.reg_sel_r1 = s1;
      bus_a.dbg_sel = ds;    bus_b.dbg_sel = ds;
      @(posedge clk);
      #1;
      for (int z = 0; z < 2; z++) begin
         exp_q.push_back(ref_read(z, rst_v, we, ws, wd, s0));
         exp_q.push_back(ref_read(z, rst_v, we, ws, wd, s1));
      end
      for (int z = 0; z < 2; z++) begin
         if (rst_v) begin
            for (int i = 0; i < NUM_REGS; i++) ref_mem[z][i] = '0;
         end else if (we && !(z == 1 && ws == 0)) begin
            ref_mem[z][ws] = wd;
         end
      end
      check("a.r0", bus_a.r0_data, exp_q.pop_front());
      check("a.r1", bus_a.r1_data, exp_q.pop_front());
      check("b.r0", bus_b.r0_data, exp_q.pop_front());
      check("b.r1", bus_b.r1_data, exp_q.pop_front());
      check("a.dbg", bus_a.dbg_data, ref_mem[0][ds]);
      check("b.dbg", bus_b.dbg_data, (ds == 0) ? word_t'(0) : ref_mem[1][ds]);
   endtask

   initial begin
      reg_idx_t ws, s0, s1, ds;
      logic we, rv;
      word_t wd;

      rst = 1'b0;
      bus_a.reg_w0_rw = 1'b0; bus_b.reg_w0_rw = 1'b0;
      bus_a.reg_sel_w0 = '0;  bus_b.reg_sel_w0 = '0;
      bus_a.w0_data = '0;     bus_b.w0_data = '0;
      bus_a.reg_sel_r0 = '0;  bus_b.reg_sel_r0 = '0;
      bus_a.reg_sel_r1 = '0;  bus_b.reg_sel_r1 = '0;
      bus_a.dbg_sel = '0;     bus_b.dbg_sel = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         ref_mem[0][i] = 'x;
         ref_mem[1][i] = 'x;
      end

      // Initial reset, then reset overriding a concurrent write to R3.
      cycle(1, 0, 0, 0, 0, 0, 0);
      cycle(0, 1, 3, 16'h1234, 0, 0, 3);
      check("plan.r3_preload", bus_a.dbg_data, 16'h1234);
      cycle(1, 1, 3, 16'hFFFF, 3, 3, 3);
      check("plan.rst_r0", bus_a.r0_data, 16'h0000);
      check("plan.rst_dbg3", bus_a.dbg_data, 16'h0000);
      cycle(0, 0, 0, 0, 3, 3, 3);
      check("plan.r3_after_rst", bus_a.r0_data, 16'h0000);

      // Basic write then read.
      cycle(0, 1, 5, 16'hBEEF, 0, 0, 5);
      check("plan.dbg5", bus_a.dbg_data, 16'hBEEF);
      cycle(0, 0, 0, 0, 5, 0, 5);
      check("plan.r5", bus_a.r0_data, 16'hBEEF);

      // Bypass on both ports.
      cycle(0, 1, 2, 16'h0011, 0, 0, 2);
      cycle(0, 1, 2, 16'h00AA, 2, 2, 2);
      check("plan.byp_r0", bus_a.r0_data, 16'h00AA);
      check("plan.byp_r1", bus_a.r1_data, 16'h00AA);

      // Dual port, unrelated write.
      cycle(0, 1, 1, 16'h1111, 0, 0, 1);
      cycle(0, 1, 6, 16'h6666, 0, 0, 6);
      cycle(0, 1, 4, 16'h4444, 1, 6, 4);
      check("plan.dual_r0", bus_a.r0_data, 16'h1111);
      check("plan.dual_r1", bus_a.r1_data, 16'h6666);

      // Zero register: write to R0 with same-edge read.
      cycle(0, 1, 0, 16'h5555, 0, 0, 0);
      check("plan.zr_r0", bus_b.r0_data, 16'h0000);
      check("plan.zr_dbg", bus_b.dbg_data, 16'h0000);
      check("plan.nzr_r0", bus_a.r0_data, 16'h5555);

      // Write enable low leaves R7 alone.
      cycle(0, 1, 7, 16'h0007, 0, 0, 7);
      cycle(0, 0, 7, 16'h7777, 7, 7, 7);
      check("plan.r7_hold", bus_a.r0_data, 16'h0007);
      check("plan.r7_dbg", bus_a.dbg_data, 16'h0007);

      // Randomized traffic with biased select collisions and occasional reset.
      for (int n = 0; n < 600; n++) begin
         rv = ($urandom_range(0, 49) == 0);
         we = ($urandom_range(0, 3) != 0);
         ws = reg_idx_t'($urandom_range(0, NUM_REGS - 1));
         wd = word_t'($urandom);
         s0 = ($urandom_range(0, 3) == 0) ? ws : reg_idx_t'($urandom_range(0, NUM_REGS - 1));
         s1 = ($urandom_range(0, 3) == 0) ? ws : reg_idx_t'($urandom_range(0, NUM_REGS - 1));
         ds = reg_idx_t'($urandom_range(0, NUM_REGS - 1));
         cycle(rv, we, ws, wd, s0, s1, ds);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Register file that responds to the control unit's register-select interface.
- Two registered read ports (r0, r1), one synchronous write port (w0), and a write-to-read bypass.
- Sits between the control unit (which drives selects and the write enable) and the ALU / write-back path (which consumes read data and supplies write data).

Parameters:
- DATA_W, 16, width of each register and of all data ports
- NUM_REGS, 8, number of architectural registers; must equal 2**SEL_W
- SEL_W, 3, width of every register-select port
- ZERO_REG, 0, when 1: register 0 always reads 0 and writes to it are discarded

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- reg_sel_r0  in  SEL_W  read port 0 register index
- reg_sel_r1  in  SEL_W  read port 1 register index
- reg_sel_w0  in  SEL_W  write port register index
- reg_w0_rw  in  1  1 = write w0_data into reg_sel_w0 this edge; 0 = no write
- w0_data  in  DATA_W  write data
- r0_data  out  DATA_W  registered read data, port 0
- r1_data  out  DATA_W  registered read data, port 1
- dbg_sel  in  SEL_W  debug index (combinational peek)
- dbg_data  out  DATA_W  combinational contents of register dbg_sel, no bypass

Behaviour:
- Interface decision: one clock, clk; reset rst is synchronous and active-high.
- Reset, sampled at the rising edge with rst=1:
  - all NUM_REGS registers cleared to 0
  - r0_data = 0, r1_data = 0
  - any write requested that edge is ignored
- Reset asserted mid-operation overrides a concurrent write. The first edge after rst falls operates normally, so reads issued then return 0 unless bypassed.
- Write: at each rising edge with rst=0 and reg_w0_rw=1, mem[reg_sel_w0] <= w0_data. With reg_w0_rw=0 storage is unchanged.
- ZERO_REG=1:
  - writes to index 0 are discarded
  - reads of index 0 (including bypass and dbg) return 0
- Read latency is 1 cycle: r0_data / r1_data after edge N reflect reg_sel_r0 / reg_sel_r1 sampled at edge N.
- Bypass: if at edge N reg_w0_rw=1 and reg_sel_w0 equals a read select, that port captures w0_data, not the old contents. This is write-before-read semantics. The ZERO_REG exclusion applies to bypass as well.
- Both read ports may select the same register; both return identical data.
- Read data is held when selects are unchanged and no write hits them. The ports re-read every edge; there is no enable.
- dbg_data is purely combinational from storage: it shows the post-edge value and never the bypass.
- Widths: no truncation or extension. Select values are always in range because NUM_REGS = 2**SEL_W. An elaboration-time check must fail if this does not hold.
- There are no X outputs after the first reset edge.

Decomposition:
- Shared package regfile_pkg holds:
  - constants DATA_W=16, SEL_W=3, NUM_REGS=8
  - typedefs reg_idx_t (logic [SEL_W-1:0]) and word_t (logic [DATA_W-1:0])
  - the control unit imports the same package for its select ports
- One sub-module, reg_file_read_port: storage-array mux, bypass compare, ZERO_REG masking, and output register. It is instantiated twice (r0, r1).
- Storage and the write logic stay in reg_file.

Test Plan:
- Reset: preload R3=0x1234, assert rst one cycle with reg_w0_rw=1, sel_w0=3, data=0xFFFF -> R3 reads 0x0000; r0_data=r1_data=0 after the reset edge.
- Basic write/read: write R5=0xBEEF at edge 1; sel_r0=5 at edge 2 -> r0_data=0xBEEF after edge 2; dbg_sel=5 shows 0xBEEF after edge 1.
- Bypass: R2=0x0011; at the same edge write R2=0x00AA with sel_r0=2, sel_r1=2 -> both outputs 0x00AA next cycle (not 0x0011).
- Dual port / no false bypass: R1=0x1111, R6=0x6666; read sel_r0=1, sel_r1=6 while writing R4=0x4444 -> r0_data=0x1111, r1_data=0x6666.
- ZERO_REG=1 build: write R0=0x5555 with sel_r0=0 same edge -> r0_data=0x0000; dbg_sel=0 shows 0x0000.
- Write-enable low: reg_w0_rw=0, sel_w0=7, data=0x7777 -> R7 retains its prior value 0x0007; a read of R7 returns 0x0007.
